// File: rtl/router_pkg.sv
// router_pkg: shared router types, flit field positions and port indices.
package router_pkg;
  typedef logic [1:0] coord_t;
  localparam int DEST_X_MSB = 1;
  localparam int DEST_X_LSB = 2;
  localparam int DEST_Y_MSB = 3;
  localparam int DEST_Y_LSB = 4;
  typedef enum logic [2:0] {N, E, S, W, L} port_e;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: register array with synchronous write and combinational read.
module fifo_mem #(
  parameter int WL = 16,
  parameter int ADDR = 4
) (
  input  logic            clk,
  input  logic            we,
  input  logic [ADDR-1:0] waddr,
  input  logic [WL-1:0]   wdata,
  input  logic [ADDR-1:0] raddr,
  output logic [WL-1:0]   rdata
);
  logic [WL-1:0] mem [2**ADDR];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/router_in_fifo.sv
// router_in_fifo: per-port FWFT input buffer exposing the head flit's destination.
module router_in_fifo
  import router_pkg::*;
#(
  parameter int WL = 16,
  parameter int ADDR = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [WL-1:0] din,
  input  logic          rd_en,
  input  logic          err_clr,
  output logic [WL-1:0] dout,
  output logic [1:0]    dest_x,
  output logic [1:0]    dest_y,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic [ADDR:0] count,
  output logic          overflow,
  output logic          underflow
);
  logic [ADDR-1:0] wr_ptr, rd_ptr;
  logic [WL-1:0] head;
  logic push, pop;
  assign empty = count == '0;
  assign full = count[ADDR];
  assign almost_full = count >= (ADDR+1)'(AF_LEVEL);
  assign push = wr_en && !full;
  assign pop = rd_en && !empty;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + ADDR'(push);
      rd_ptr <= rd_ptr + ADDR'(pop);
      count <= count + (ADDR+1)'(push) - (ADDR+1)'(pop);
      overflow <= (overflow && !err_clr) || (wr_en && full);
      underflow <= (underflow && !err_clr) || (rd_en && empty);
    end
  fifo_mem #(.WL(WL), .ADDR(ADDR)) u_mem (
    .clk(clk),
    .we(push),
    .waddr(wr_ptr),
    .wdata(din),
    .raddr(rd_ptr),
    .rdata(head)
  );
  // Gate the head while empty so stale memory never reaches the route stage.
  assign dout = empty ? '0 : head;
  assign dest_x = dout[WL-DEST_X_MSB:WL-DEST_X_LSB];
  assign dest_y = dout[WL-DEST_Y_MSB:WL-DEST_Y_LSB];
endmodule

// File: doc/router_in_fifo.md
Name: router_in_fifo

Overview:
- Per-port input buffer of the 4x4 mesh router. One instance per direction (N, E, S, W, L).
- Sits directly upstream of the route/arbitration stage.
- Stores incoming flits. Presents the head flit first-word-fall-through, together with its decoded destination coordinates and an empty flag.
- Pops the head when the crossbar grants it.

Parameters:
- WL, 16, flit width in bits.
- ADDR, 4, pointer width; depth = 2**ADDR = 16 flits.
- AF_LEVEL, 12, occupancy at or above which almost_full asserts.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  push request from upstream link.
- din  input  WL  flit to push.
- rd_en  input  1  pop request (grant from arbiter/crossbar for this port).
- err_clr  input  1  synchronous clear of sticky error flags.
- dout  output  WL  head flit (FWFT).
- dest_x  output  2  head flit destination X = dout[WL-1:WL-2].
- dest_y  output  2  head flit destination Y = dout[WL-3:WL-4].
- empty  output  1  no flits stored.
- full  output  1  2**ADDR flits stored.
- almost_full  output  1  count >= AF_LEVEL; used as link backpressure.
- count  output  ADDR+1  current occupancy, 0..2**ADDR.
- overflow  output  1  sticky: a push was attempted while full.
- underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (rst_n low, async assert, sync-free deassert):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, almost_full=0, overflow=0, underflow=0.
  - Memory contents are not reset.
- Push accepted iff wr_en && !full:
  - mem[wr_ptr] <= din; wr_ptr increments modulo 2**ADDR (natural wrap of an ADDR-bit pointer).
- Pop accepted iff rd_en && !empty:
  - rd_ptr increments modulo 2**ADDR.
- Occupancy:
  - count +1 on push only, -1 on pop only.
  - Unchanged when both are accepted in the same cycle, or when neither is.
- Simultaneous push and pop when full: pop accepted, push rejected (full is evaluated pre-edge). Count becomes 2**ADDR-1; overflow sets.
- Simultaneous push and pop when empty: push accepted, pop rejected. Count becomes 1; underflow sets.
- Status flags are derived combinationally from count (registered state):
  - empty = (count==0)
  - full = (count==2**ADDR)
  - almost_full = (count>=AF_LEVEL)
- Head presentation (latency):
  - dout = mem[rd_ptr] via combinational read.
  - A flit pushed into an empty FIFO appears on dout/dest_x/dest_y and empty deasserts in the cycle after the push edge, i.e. 1-cycle write-to-visible latency.
  - After a pop edge, the next flit is visible immediately.
- When empty: dout, dest_x and dest_y are forced to 0, so downstream never sees stale X/Y.
- Error flags:
  - overflow sets on wr_en && full; underflow sets on rd_en && empty.
  - Both hold until err_clr=1 or reset.
  - If err_clr and a new error coincide, the flag remains set (set wins).
- No data forwarding din->dout in the same cycle; a push to an empty FIFO is never poppable in that cycle.
- Reset mid-operation: all stored flits are discarded immediately; empty asserts asynchronously.

Decomposition:
- Shared package router_pkg holds:
  - coord_t (logic [1:0]).
  - Flit field constants DEST_X_MSB/LSB and DEST_Y_MSB/LSB, expressed relative to WL.
  - Port index enum N, E, S, W, L.
- The same package is used by the arbiter and crossbar.
- One natural sub-module: fifo_mem (2**ADDR x WL register array, synchronous write, combinational read).
- Pointer, count and flag logic stay in router_in_fifo.

Test Plan:
- Reset then push din=16'hB123 -> next cycle empty=0, count=1, dest_x=2, dest_y=3, dout=16'hB123.
- Push 16 flits 16'h0000..16'h000F, no pops -> full=1, count=16, almost_full asserted from count=12. A 17th push leaves count=16 and sets overflow=1. Pops then return 0x0000..0x000F in order.
- Fill to 16, then assert wr_en and rd_en together -> count=15, head advances to 2nd flit, overflow=1. err_clr then clears overflow.
- Empty FIFO, assert rd_en and wr_en (din=16'h4000) together -> count=1, underflow=1, next cycle dout=16'h4000, dest_x=1, dest_y=0.
- Wrap-around: push 10, pop 10, push 10 -> write pointer wraps past 15 to 4. Pops return the second 10 in order, count returns to 0, empty=1, dout=0.
- With count=5, drop rst_n mid-cycle -> empty=1, count=0 asynchronously. After release, a single push/pop round-trips correctly.
